// File: rtl/ysyx_24120013_imem_resp_pkg.sv
// Shared constants and types for the instruction-memory responder.
package ysyx_24120013_imem_resp_pkg;

    localparam int          IMEM_ADDR_WIDTH = 32;
    localparam int          IMEM_DATA_WIDTH = 32;
    localparam int          IMEM_DEPTH_LOG2 = 10;
    localparam int          IMEM_LATENCY    = 2;
    localparam logic [31:0] IMEM_BASE_ADDR  = 32'h8000_0000;

    // Wide enough for the largest legal LATENCY (15).
    localparam int          IMEM_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } imem_state_e;

    // Counter preload for a given latency: the accept edge itself counts as one cycle.
    function automatic logic [IMEM_CNT_W-1:0] imem_cnt_init(input int latency);
        return IMEM_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/ysyx_24120013_imem_resp_if.sv
// Fetch request/response handshake between a fetching unit and the responder.
interface ysyx_24120013_imem_resp_if
    import ysyx_24120013_imem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    // Fetching unit side.
    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    // Memory responder side.
    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/ysyx_24120013_imem_array.sv
// Word storage: synchronous write port, combinational read port, never reset.
module ysyx_24120013_imem_array
    import ysyx_24120013_imem_resp_pkg::*;
#(
    parameter int DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int DEPTH_LOG2 = IMEM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    // Backdoor program load; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ysyx_24120013_imem_resp.sv
// Instruction-memory responder: one outstanding fetch, fixed latency, fault on
// misaligned or out-of-range addresses.
module ysyx_24120013_imem_resp
    import ysyx_24120013_imem_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = IMEM_DATA_WIDTH,
    parameter int                    DEPTH_LOG2 = IMEM_DEPTH_LOG2,
    parameter int                    LATENCY    = IMEM_LATENCY,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(IMEM_BASE_ADDR)
) (
    input  logic                       clk,
    input  logic                       rst,
    ysyx_24120013_imem_resp_if.slave   bus,
    input  logic                       ld_en,
    input  logic [DEPTH_LOG2-1:0]      ld_addr,
    input  logic [DATA_WIDTH-1:0]      ld_data
);
    localparam logic [ADDR_WIDTH-1:0] NUM_WORDS = ADDR_WIDTH'(2**DEPTH_LOG2);
    localparam logic [IMEM_CNT_W-1:0] CNT_INIT  = imem_cnt_init(LATENCY);

    imem_state_e           state_q, state_d;
    logic [IMEM_CNT_W-1:0] cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  err_q,   err_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] word_off;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  fault;
    logic                  accept;
    logic                  resp_active;

    // Addresses below BASE_ADDR wrap to a huge offset and land out of range.
    assign offset   = bus.req_addr - BASE_ADDR;
    assign word_off = offset >> 2;
    assign rd_idx   = word_off[DEPTH_LOG2-1:0];
    assign fault    = (|bus.req_addr[1:0]) || (word_off >= NUM_WORDS);

    // Read happens before this edge's load write, so a colliding load yields the old word.
    ysyx_24120013_imem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign resp_active   = (state_q == ST_RESP);
    assign bus.resp_valid = resp_active;
    assign bus.resp_data  = resp_active ? data_q : '0;
    assign bus.resp_err   = resp_active ? err_q  : 1'b0;

    // Next-state logic: capture on accept, count down the latency, hold until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = fault ? '0 : rd_word;
                    err_d   = fault;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= IMEM_CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - IMEM_CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    data_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and response registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/ysyx_24120013_imem_resp.md
YSYX_24120013_IMEM_RESP -- requirements
Module: ysyx_24120013_imem_resp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: fetch address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: instruction word width in bits.
REQ-003 SHALL have parameter DEPTH_LOG2, default 10: log2 of the word count of the storage array.
REQ-004 SHALL have parameter LATENCY, default 2 (legal 1..15): cycles from request accept to resp_valid.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-006 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have ports: req_valid  input  1  fetch request present.
REQ-009 SHALL have ports: req_ready  output  1  responder can accept a request.
REQ-010 SHALL have ports: req_addr  input  ADDR_WIDTH  byte address (the fetching unit's pc).
REQ-011 SHALL have ports: resp_valid  output  1  response present.
REQ-012 SHALL have ports: resp_ready  input  1  fetching unit takes the response.
REQ-013 SHALL have ports: resp_data  output  DATA_WIDTH  instruction word.
REQ-014 SHALL have ports: resp_err  output  1  access fault (misaligned or out of range).
REQ-015 SHALL have ports: ld_en  input  1  backdoor program-load write strobe.
REQ-016 SHALL have ports: ld_addr  input  DEPTH_LOG2  word index for the load write.
REQ-017 SHALL have ports: ld_data  input  DATA_WIDTH  word for the load write.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, WAIT, RESP; one outstanding request maximum.
REQ-019 SHALL drive req_ready = 1 only in IDLE; a request is accepted on an edge with req_valid && req_ready.
REQ-020 SHALL, on accept, register the address, compute the fault flag, read the storage word into the response register, load a latency counter with LATENCY-1, and move to WAIT (to RESP directly when LATENCY = 1).
REQ-021 SHALL, in WAIT, decrement the counter each cycle and enter RESP when it reaches 0, so that resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-022 SHALL hold resp_valid, resp_data and resp_err stable in RESP until resp_ready is sampled high, then return to IDLE; there is no same-cycle re-accept (back-to-back throughput of one fetch per LATENCY+1 cycles minimum).
REQ-023 SHALL flag fault when req_addr[1:0] != 0 or (req_addr - BASE_ADDR) >> 2 >= 2**DEPTH_LOG2 (unsigned; addresses below BASE_ADDR wrap and fault); on fault, resp_data = 0 and resp_err = 1.
REQ-024 SHALL compute the word index as (req_addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits.
REQ-025 SHALL perform ld_en writes on any edge regardless of FSM state; a write and an accept to the same word on the same edge returns the old word (read-before-write).
REQ-026 SHALL not affect an already-registered response with a later load write.
REQ-027 SHALL hold resp_data = 0 and resp_err = 0 whenever resp_valid = 0.
REQ-028 SHALL ignore req_addr and req_valid changes outside the accept edge.

Reset
REQ-029 SHALL on rst high force IDLE, req_ready = 0 during the reset cycle, resp_valid = 0, resp_data = 0, resp_err = 0, counter = 0.
REQ-030 SHALL abandon any in-flight request on reset mid-WAIT or mid-RESP without emitting a response.
REQ-031 SHALL not clear storage contents on reset; ld_en writes taken during reset remain valid.

Structure
REQ-032 SHALL place state encodings, default BASE_ADDR and width constants in the shared ysyx_24120013 package/header.
REQ-033 SHALL isolate storage in one sub-module ysyx_24120013_imem_array (sync write, combinational read, 2**DEPTH_LOG2 x DATA_WIDTH).

Verification
REQ-034 SHALL cover: load word 0 = 32'h0000_0413, request 32'h8000_0000 (LATENCY=2) -> resp_valid 2 cycles after accept, resp_data 32'h0000_0413, resp_err 0.
REQ-035 SHALL cover: request 32'h8000_0002 -> resp_err 1, resp_data 0; request 32'h8000_1000 with DEPTH_LOG2=10 -> resp_err 1; request 32'h7FFF_FFFC -> resp_err 1.
REQ-036 SHALL cover: resp_ready held low 5 cycles -> resp_valid/resp_data unchanged, req_ready 0 throughout; resp_ready high -> IDLE next cycle.
REQ-037 SHALL cover: ld_en to word 3 with 32'hDEAD_BEEF on the accept edge for word 3 (old 32'h1111_1111) -> resp_data 32'h1111_1111; next fetch -> 32'hDEAD_BEEF.
REQ-038 SHALL cover: rst asserted one cycle during WAIT -> no resp_valid ever for that request, outputs 0, req_ready 1 the cycle after rst drops.
REQ-039 SHALL cover: LATENCY=1 back-to-back fetches with resp_ready tied high -> one response every 2 cycles, sequential pcs 0x8000_0000, 0x8000_0004 return words 0 and 1.
